// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: pipelined byte/half/word access, configurable wait states, two-cycle ERROR.
// Optional build macro AHB_SRAM_PRIV_CHECK_EN rejects user-mode (hprot[1]=0) writes with ERROR.
module ahb_sram_slave #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 1024,
  parameter int                    WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  s_hsel_in,
  input  logic [ADDR_WIDTH-1:0] s_haddr_in,
  input  logic [1:0]            s_htrans_in,
  input  logic [2:0]            s_hsize_in,
  input  logic [2:0]            s_hburst_in,
  input  logic [3:0]            s_hprot_in,
  input  logic                  s_hwrite_in,
  input  logic                  s_hmastlock_in,
  input  logic [DATA_WIDTH-1:0] s_hwdata_in,
  input  logic                  s_hready_in,
  output logic                  s_hready_out,
  output logic                  s_hresp_out,
  output logic [DATA_WIDTH-1:0] s_hrdata_out
);

  localparam int         IDX_W = $clog2(MEM_DEPTH);
  localparam int         HI_W  = ADDR_WIDTH - IDX_W - 2;
  localparam logic [3:0] WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERR1  = 2'd2,
    ST_ERR2  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_cnt;
  logic [3:0]              w_cnt_nxt;
  logic                    r_dp_valid;
  logic                    w_dp_valid_nxt;
  logic [IDX_W-1:0]        r_widx;
  logic [3:0]              r_mask;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

  logic                    w_addr_ok;
  logic                    w_accept;
  logic [ADDR_WIDTH-1:0]   w_off;
  logic                    w_misalign;
  logic                    w_range_err;
  logic                    w_priv_err;
  logic                    w_err;
  logic                    w_data_phase;
  logic                    w_commit;
  logic                    w_unused;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lane);
    logic [3:0] mask;
    case (size)
      3'd0:    mask = 4'b0001 << lane;
      3'd1:    mask = lane[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  assign w_addr_ok   = (r_state == ST_READY) || (r_state == ST_ERR2);
  assign w_accept    = w_addr_ok & s_hsel_in & s_hready_in & s_htrans_in[1];
  assign w_off       = s_haddr_in - BASE_ADDR;
  assign w_misalign  = (s_hsize_in > 3'd2)
                     | ((s_hsize_in == 3'd1) & s_haddr_in[0])
                     | ((s_hsize_in == 3'd2) & (s_haddr_in[1:0] != 2'b00));
  // Base-relative offset beyond the array shows up as any set bit above the word index.
  assign w_range_err = (w_off[ADDR_WIDTH-1:IDX_W+2] != {HI_W{1'b0}}) | (s_haddr_in < BASE_ADDR);

`ifdef AHB_SRAM_PRIV_CHECK_EN
  assign w_priv_err  = s_hwrite_in & ~s_hprot_in[1];
`else
  assign w_priv_err  = 1'b0;
`endif

  assign w_err        = w_misalign | w_range_err | w_priv_err;
  assign w_data_phase = (r_state == ST_READY) & r_dp_valid;
  assign w_commit     = w_data_phase & r_write;

  assign s_hready_out = w_addr_ok;
  assign s_hresp_out  = (r_state == ST_ERR1) || (r_state == ST_ERR2);
  assign s_hrdata_out = (w_data_phase & ~r_write) ? r_mem[r_widx] : {DATA_WIDTH{1'b0}};

  assign w_unused = ^{s_hburst_in, s_hmastlock_in, s_htrans_in[0], s_hprot_in, w_off[1:0]};

  // State, wait counter and data-phase flag.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state    <= ST_READY;
      r_cnt      <= 4'd0;
      r_dp_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dp_valid <= w_dp_valid_nxt;
    end
  end

  // Next-state logic; ERR2 accepts exactly like READY.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_dp_valid_nxt = 1'b0;
    case (r_state)
      ST_READY, ST_ERR2: begin
        if (w_accept && w_err) begin
          w_state_nxt = ST_ERR1;
        end else if (w_accept && (WAIT_STATES > 0)) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = WS_M1;
        end else if (w_accept) begin
          w_state_nxt    = ST_READY;
          w_dp_valid_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_READY;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt    = ST_READY;
          w_dp_valid_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_ERR1: begin
        w_state_nxt = ST_ERR2;
      end
      default: begin
        w_state_nxt = ST_READY;
      end
    endcase
  end

  // Address-phase capture for the following data phase.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_widx  <= {IDX_W{1'b0}};
      r_mask  <= 4'b0000;
      r_write <= 1'b0;
    end else if (w_accept) begin
      r_widx  <= w_off[IDX_W+1:2];
      r_mask  <= lane_mask(s_hsize_in, s_haddr_in[1:0]);
      r_write <= s_hwrite_in;
    end
  end

  // Byte-lane write commit at the end of a write data phase; array has no reset.
  always_ff @(posedge hclk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_mask[b]) begin
          r_mem[r_widx][8*b +: 8] <= s_hwdata_in[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: three instances (0/2/3 wait states) checked every cycle against a transaction model.
module tb_ahb_sram_slave;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic [2:0]  rstn;
  logic [2:0]  sel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [2:0]  rdy;
  logic [2:0]  rsp;
  logic [31:0] rdt [3];

  int unsigned ws_v   [3] = '{0, 2, 3};
  logic [31:0] base_v [3] = '{32'h0, 32'h0, 32'h400};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ahb_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u0 (
    .hclk(clk), .hresetn(rstn[0]), .s_hsel_in(sel[0]), .s_haddr_in(haddr), .s_htrans_in(htrans),
    .s_hsize_in(hsize), .s_hburst_in(3'b000), .s_hprot_in(hprot), .s_hwrite_in(hwrite),
    .s_hmastlock_in(1'b0), .s_hwdata_in(hwdata), .s_hready_in(rdy[0]), .s_hready_out(rdy[0]),
    .s_hresp_out(rsp[0]), .s_hrdata_out(rdt[0]));
  ahb_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(2), .BASE_ADDR(32'h0)) u1 (
    .hclk(clk), .hresetn(rstn[1]), .s_hsel_in(sel[1]), .s_haddr_in(haddr), .s_htrans_in(htrans),
    .s_hsize_in(hsize), .s_hburst_in(3'b000), .s_hprot_in(hprot), .s_hwrite_in(hwrite),
    .s_hmastlock_in(1'b0), .s_hwdata_in(hwdata), .s_hready_in(rdy[1]), .s_hready_out(rdy[1]),
    .s_hresp_out(rsp[1]), .s_hrdata_out(rdt[1]));
  ahb_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(3), .BASE_ADDR(32'h400)) u2 (
    .hclk(clk), .hresetn(rstn[2]), .s_hsel_in(sel[2]), .s_haddr_in(haddr), .s_htrans_in(htrans),
    .s_hsize_in(hsize), .s_hburst_in(3'b000), .s_hprot_in(hprot), .s_hwrite_in(hwrite),
    .s_hmastlock_in(1'b0), .s_hwdata_in(hwdata), .s_hready_in(rdy[2]), .s_hready_out(rdy[2]),
    .s_hresp_out(rsp[2]), .s_hrdata_out(rdt[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: per slave, one outstanding transfer with a count of stall cycles left.
  logic [31:0] mm    [3][DEPTH];
  bit          busy  [3];
  int          left  [3];
  bit          merr  [3];
  bit          mwr   [3];
  int          midx  [3];
  int          mlo   [3];
  int          mlen  [3];

  initial begin
    logic        e_rdy;
    logic        e_rsp;
    logic [31:0] e_rd;
    logic [31:0] off;
    bit          acc_ok;
    bit          e;
    for (int k = 0; k < 3; k++) busy[k] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rstn[k]) busy[k] = 1'b0;
        e_rdy = !busy[k] || (left[k] == 0);
        e_rsp = busy[k] && merr[k];
        e_rd  = (busy[k] && left[k] == 0 && !merr[k] && !mwr[k]) ? mm[k][midx[k]] : 32'h0;
        chk($sformatf("model.rdy%0d", k), {31'd0, rdy[k]}, {31'd0, e_rdy});
        chk($sformatf("model.resp%0d", k), {31'd0, rsp[k]}, {31'd0, e_rsp});
        chk($sformatf("model.rdata%0d", k), rdt[k], e_rd);
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rstn[k]) begin
          busy[k] = 1'b0;
        end else begin
          acc_ok = !busy[k] || (left[k] == 0);
          if (busy[k] && left[k] > 0) begin
            left[k]--;
          end else if (busy[k]) begin
            if (!merr[k] && mwr[k])
              for (int b = 0; b < 4; b++)
                if (b >= mlo[k] && b < mlo[k] + mlen[k])
                  mm[k][midx[k]][8*b +: 8] = hwdata[8*b +: 8];
            busy[k] = 1'b0;
          end
          if (acc_ok && sel[k] && htrans[1]) begin
            off = haddr - base_v[k];
            e = (hsize > 3'd2) || ((haddr % (32'd1 << hsize)) != 32'd0) ||
                (haddr < base_v[k]) || (off >= 32'(DEPTH * 4));
`ifdef AHB_SRAM_PRIV_CHECK_EN
            if (hwrite && !hprot[1]) e = 1'b1;
`endif
            busy[k] = 1'b1;
            merr[k] = e;
            mwr[k]  = hwrite;
            midx[k] = int'((off / 32'd4) % 32'(DEPTH));
            mlo[k]  = int'(haddr % 32'd4);
            mlen[k] = 1 << hsize;
            left[k] = e ? 1 : int'(ws_v[k]);
          end
        end
      end
    end
  end

  task automatic aph(input logic [31:0] a, input logic [2:0] sz, input logic wr);
    haddr  = a;
    hsize  = sz;
    hwrite = wr;
    htrans = 2'b10;
  endtask

  // One non-pipelined transfer; returns data-phase read data, response and stall count.
  task automatic xfer(input int k, input logic [31:0] a, input logic [2:0] sz, input logic wr,
                      input logic [31:0] wd, input logic [3:0] prot,
                      output logic [31:0] rd, output logic rs, output int stalls);
    int  n;
    bit  r;
    sel   = 3'b001 << k;
    hprot = prot;
    aph(a, sz, wr);
    n = 0;
    do begin
      @(negedge clk);
      r = rdy[k];
      @(posedge clk); #1;
      n++;
    end while (!r && n < 50);
    htrans = 2'b00;
    hwdata = wd;
    stalls = 0;
    rd = 32'h0;
    rs = 1'b0;
    r  = 1'b0;
    n  = 0;
    while (!r && n < 50) begin
      @(negedge clk);
      if (rdy[k]) begin
        r  = 1'b1;
        rd = rdt[k];
        rs = rsp[k];
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
      n++;
    end
    if (!r) chk("xfer.timeout", 32'd0, 32'd1);
    sel   = 3'b000;
    hprot = 4'b0011;
  endtask

  initial begin
    logic [31:0] rd;
    logic        rs;
    int          st;
    rstn = 3'b000; sel = 3'b000; haddr = 32'h0; htrans = 2'b00; hsize = 3'd0;
    hwrite = 1'b0; hprot = 4'b0011; hwdata = 32'h0;
    #1;
    chk("reset.rdy", {29'd0, rdy}, 32'd7);
    chk("reset.resp", {29'd0, rsp}, 32'd0);
    chk("reset.rdata", rdt[0], 32'h0);
    repeat (2) @(posedge clk);
    #1 rstn = 3'b111;
    @(posedge clk); #1;

    // Back-to-back pipelined write then read on the zero-wait slave.
    sel = 3'b001;
    aph(32'h10, 3'd2, 1'b1);
    @(posedge clk); #1;
    aph(32'h10, 3'd2, 1'b0);
    hwdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("pipe.wr.rdy", {31'd0, rdy[0]}, 32'd1);
    @(posedge clk); #1;
    htrans = 2'b00;
    @(negedge clk);
    chk("pipe.rd.data", rdt[0], 32'hDEADBEEF);
    chk("pipe.rd.rdy", {31'd0, rdy[0]}, 32'd1);
    chk("pipe.rd.resp", {31'd0, rsp[0]}, 32'd0);
    @(posedge clk); #1;
    sel = 3'b000;

    xfer(0, 32'h11, 3'd0, 1'b1, 32'hAAAAAAAA, 4'b0011, rd, rs, st);
    xfer(0, 32'h10, 3'd2, 1'b0, 32'h0, 4'b0011, rd, rs, st);
    chk("byte.rd", rd, 32'hDEADAAEF);
    xfer(0, 32'h12, 3'd1, 1'b1, 32'h12345678, 4'b0011, rd, rs, st);
    xfer(0, 32'h10, 3'd2, 1'b0, 32'h0, 4'b0011, rd, rs, st);
    chk("half.rd", rd, 32'h1234AAEF);
    chk("half.rd.stalls", 32'(st), 32'd0);

    xfer(0, 32'h12, 3'd2, 1'b0, 32'h0, 4'b0011, rd, rs, st);
    chk("misalign.resp", {31'd0, rs}, 32'd1);
    chk("misalign.stalls", 32'(st), 32'd1);
    xfer(0, 32'h100, 3'd2, 1'b1, 32'hFFFFFFFF, 4'b0011, rd, rs, st);
    chk("range.resp", {31'd0, rs}, 32'd1);
    xfer(0, 32'h10, 3'd3, 1'b0, 32'h0, 4'b0011, rd, rs, st);
    chk("size3.resp", {31'd0, rs}, 32'd1);
    xfer(0, 32'h10, 3'd2, 1'b0, 32'h0, 4'b0011, rd, rs, st);
    chk("err.nowrite", rd, 32'h1234AAEF);

    xfer(0, 32'h14, 3'd2, 1'b1, 32'h0, 4'b0011, rd, rs, st);
    xfer(0, 32'h14, 3'd2, 1'b1, 32'hCAFEF00D, 4'b0001, rd, rs, st);
    xfer(0, 32'h14, 3'd2, 1'b0, 32'h0, 4'b0011, rd, rs, st);
`ifdef AHB_SRAM_PRIV_CHECK_EN
    chk("priv.user.rd", rd, 32'h0);
`else
    chk("priv.user.rd", rd, 32'hCAFEF00D);
`endif
    xfer(0, 32'h14, 3'd2, 1'b1, 32'h600DF00D, 4'b0011, rd, rs, st);
    chk("priv.ok.resp", {31'd0, rs}, 32'd0);
    xfer(0, 32'h14, 3'd2, 1'b0, 32'h0, 4'b0011, rd, rs, st);
    chk("priv.ok.rd", rd, 32'h600DF00D);

    // Two wait states.
    xfer(1, 32'h10, 3'd2, 1'b1, 32'h55AA55AA, 4'b0011, rd, rs, st);
    chk("ws2.wr.stalls", 32'(st), 32'd2);
    xfer(1, 32'h10, 3'd2, 1'b0, 32'h0, 4'b0011, rd, rs, st);
    chk("ws2.rd.stalls", 32'(st), 32'd2);
    chk("ws2.rd", rd, 32'h55AA55AA);

    sel = 3'b010;
    aph(32'h10, 3'd2, 1'b1);
    hwdata = 32'hFFFFFFFF;
    htrans = 2'b00;
    @(negedge clk); chk("idle.rdy", {31'd0, rdy[1]}, 32'd1);
    @(posedge clk); #1;
    htrans = 2'b01;
    @(negedge clk); chk("busy.rdy", {31'd0, rdy[1]}, 32'd1);
    @(posedge clk); #1;
    sel = 3'b000; htrans = 2'b10;
    @(negedge clk); chk("nosel.rdy", {31'd0, rdy[1]}, 32'd1);
    @(posedge clk); #1;
    htrans = 2'b00;
    @(negedge clk); chk("nosel.rdy2", {31'd0, rdy[1]}, 32'd1);
    @(posedge clk); #1;
    xfer(1, 32'h10, 3'd2, 1'b0, 32'h0, 4'b0011, rd, rs, st);
    chk("idle.nowrite", rd, 32'h55AA55AA);

    // Three wait states, base 0x400, reset during the second wait cycle.
    xfer(2, 32'h420, 3'd2, 1'b1, 32'h11111111, 4'b0011, rd, rs, st);
    xfer(2, 32'h420, 3'd2, 1'b0, 32'h0, 4'b0011, rd, rs, st);
    chk("ws3.rd", rd, 32'h11111111);
    chk("ws3.rd.stalls", 32'(st), 32'd3);
    sel = 3'b100;
    aph(32'h420, 3'd2, 1'b1);
    @(posedge clk); #1;
    htrans = 2'b00;
    hwdata = 32'hBADBAD00;
    @(negedge clk); chk("abort.wait1", {31'd0, rdy[2]}, 32'd0);
    @(posedge clk); #1;
    sel = 3'b000;
    #3 rstn[2] = 1'b0;
    #1;
    chk("abort.rdy", {31'd0, rdy[2]}, 32'd1);
    chk("abort.resp", {31'd0, rsp[2]}, 32'd0);
    chk("abort.rdata", rdt[2], 32'h0);
    repeat (2) @(posedge clk);
    #1 rstn[2] = 1'b1;
    @(posedge clk); #1;
    xfer(2, 32'h420, 3'd2, 1'b0, 32'h0, 4'b0011, rd, rs, st);
    chk("abort.nowrite", rd, 32'h11111111);

    xfer(2, 32'h3FC, 3'd2, 1'b0, 32'h0, 4'b0011, rd, rs, st);
    chk("below.resp", {31'd0, rs}, 32'd1);
    xfer(2, 32'h500, 3'd2, 1'b0, 32'h0, 4'b0011, rd, rs, st);
    chk("above.resp", {31'd0, rs}, 32'd1);
    xfer(2, 32'h4FC, 3'd2, 1'b0, 32'h0, 4'b0011, rd, rs, st);
    chk("top.resp", {31'd0, rs}, 32'd0);
    xfer(2, 32'h421, 3'd1, 1'b1, 32'h0, 4'b0011, rd, rs, st);
    chk("half.mis.resp", {31'd0, rs}, 32'd1);
    xfer(2, 32'h420, 3'd2, 1'b0, 32'h0, 4'b0011, rd, rs, st);
    chk("ws3.final", rd, 32'h11111111);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
